regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: two write-back request channels, the shared
// register-file write port and the two read-port hazard probes.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    // ALU write-back request channel
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    // Memory-load write-back request channel
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    // Register-file write port
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Read-port hazard probes
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_busy1;
    logic              rd_busy2;

    // Datapath side: issues write-backs, probes hazards, consumes the write port
    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output rd_addr1, rd_addr2,
        input  alu_ready, mem_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  rd_busy1, rd_busy2
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  rd_addr1, rd_addr2,
        output alu_ready, mem_ready,
        output rf_we, rf_waddr, rf_wdata,
        output rd_busy1, rd_busy2
    );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// Two requesters (ALU results, memory loads) each feed a small FIFO; one head
// is granted per cycle round-robin into a registered write stage. The block
// also tracks every in-flight write so readers can stall on a pending
// destination. A register never has writes sitting in both FIFOs at once,
// which keeps per-register write order intact across requesters.
// ADDR_W/DATA_W must match the parameters of the connected interface.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Index 0 is the ALU side, index 1 the memory-load side throughout.
    typedef enum logic {
        SIDE_ALU = 1'b0,
        SIDE_MEM = 1'b1
    } side_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Incoming requests, side-indexed
    logic [1:0]       req_valid;
    wb_entry_t        req_entry [2];

    // FIFO storage and bookkeeping, side-indexed
    wb_entry_t        fifo_mem  [2][DEPTH];
    logic [DEPTH-1:0] slot_vld  [2];
    logic [PTR_W-1:0] wr_ptr    [2];
    logic [PTR_W-1:0] rd_ptr    [2];
    logic [CNT_W-1:0] count     [2];

    logic [1:0]       fifo_full;
    logic [1:0]       head_vld;
    logic [1:0]       req_conflict;
    logic [1:0]       req_ready;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             same_reg_tie;
    logic             hit1;
    logic             hit2;

    // Arbitration
    side_e            rr_next_side;
    side_e            grant_side;
    logic             grant_any;
    wb_entry_t        grant_entry;

    // Registered write stage
    logic              out_we;
    logic [ADDR_W-1:0] out_waddr;
    logic [DATA_W-1:0] out_wdata;

    // Present both request channels in side-indexed form
    always_comb begin
        req_valid    = {bus.mem_valid, bus.alu_valid};
        req_entry[0] = '{rd: bus.alu_reg, data: bus.alu_data};
        req_entry[1] = '{rd: bus.mem_reg, data: bus.mem_data};
    end

    // Scan every occupied slot: cross-FIFO conflicts and read-port hazards
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it holding its old value (which would infer a latch).
        req_conflict = '0;
        hit1         = 1'b0;
        hit2         = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_vld[s][i]) begin
                    if (fifo_mem[s][i].rd == req_entry[1 - s].rd) req_conflict[1 - s] = 1'b1;
                    if (fifo_mem[s][i].rd == bus.rd_addr1)        hit1 = 1'b1;
                    if (fifo_mem[s][i].rd == bus.rd_addr2)        hit2 = 1'b1;
                end
            end
        end
    end

    // Acceptance: room in own FIFO, no same-register entry in the other FIFO;
    // on a same-cycle tie for one register the ALU wins
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            fifo_full[s] = (count[s] == FULL_CNT);
            head_vld[s]  = (count[s] != '0);
        end
        same_reg_tie = bus.alu_valid && bus.mem_valid &&
                       (bus.alu_reg == bus.mem_reg) && (bus.alu_reg != '0);
        req_ready[0] = !fifo_full[0] && !(req_conflict[0] && (req_entry[0].rd != '0));
        req_ready[1] = !fifo_full[1] && !(req_conflict[1] && (req_entry[1].rd != '0)) &&
                       !same_reg_tie;
        push         = req_valid & req_ready;
    end

    // Round-robin grant between the two FIFO heads
    always_comb begin
        grant_any = |head_vld;
        if (&head_vld) begin
            grant_side = rr_next_side;
        end else if (head_vld[0]) begin
            grant_side = SIDE_ALU;
        end else begin
            grant_side = SIDE_MEM;
        end
        pop[0]      = grant_any && (grant_side == SIDE_ALU);
        pop[1]      = grant_any && (grant_side == SIDE_MEM);
        grant_entry = (grant_side == SIDE_MEM) ? fifo_mem[1][rd_ptr[1]]
                                               : fifo_mem[0][rd_ptr[0]];
    end

    // FIFO pointers, occupancy and per-slot valid bits
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr[s]   <= '0;
                rd_ptr[s]   <= '0;
                count[s]    <= '0;
                slot_vld[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                count[s]    <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
                slot_vld[s] <= (slot_vld[s] & ~({DEPTH{pop[s]}}  & (DEPTH'(1) << rd_ptr[s]))) |
                               ({DEPTH{push[s]}} & (DEPTH'(1) << wr_ptr[s]));
            end
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; slot_vld and count decide what is live, so stale contents are never observed.
        for (int s = 0; s < 2; s++) begin
            if (push[s]) fifo_mem[s][wr_ptr[s]] <= req_entry[s];
        end
    end

    // Write stage load and round-robin pointer update; register 0 is dropped here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_we       <= 1'b0;
            out_waddr    <= '0;
            out_wdata    <= '0;
            rr_next_side <= SIDE_ALU;
        end else if (grant_any) begin
            out_we       <= (grant_entry.rd != '0);
            out_waddr    <= grant_entry.rd;
            out_wdata    <= grant_entry.data;
            rr_next_side <= (grant_side == SIDE_ALU) ? SIDE_MEM : SIDE_ALU;
        end else begin
            out_we       <= 1'b0;
        end
    end

    assign bus.alu_ready = req_ready[0];
    assign bus.mem_ready = req_ready[1];
    assign bus.rf_we     = out_we;
    assign bus.rf_waddr  = out_waddr;
    assign bus.rf_wdata  = out_wdata;

    // A destination stays busy from acceptance until its register-file write edge
    assign bus.rd_busy1 = (bus.rd_addr1 != '0) &&
                          (hit1 || (out_we && (out_waddr == bus.rd_addr1)));
    assign bus.rd_busy2 = (bus.rd_addr2 != '0) &&
                          (hit2 || (out_we && (out_waddr == bus.rd_addr2)));

endmodule
